dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder on the pipeline's data-memory port: it receives read/write requests and holds off the core with a stall signal until each request completes.
- Acts as the initiator on a 128-bit block-wide memory bus.
- Sits between the pipelined core's MEM stage and main memory; instantiated once per core.

Parameters:
- NUM_LINES, 8, number of cache lines; power of two, minimum 2.
- INDEX_W, 3, log2(NUM_LINES); must be kept consistent with NUM_LINES.
- TAG_W, 25, equals 28-INDEX_W; must be kept consistent with INDEX_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  core word-read request.
- proc_write  in  1  core word-write request.
- proc_addr  in  30  core word address: tag [29:2+INDEX_W], index [INDEX_W+1:2], word offset [1:0].
- proc_wdata  in  32  core write data.
- proc_stall  out  1  high while the current request cannot complete this cycle.
- proc_rdata  out  32  read data; valid when proc_read=1 and proc_stall=0.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_addr  out  28  block address, {tag, index}.
- mem_wdata  out  128  block write data; word 0 in bits [31:0].
- mem_ready  in  1  one-cycle pulse; completes the outstanding memory request.
- mem_rdata  in  128  block read data; valid when mem_ready=1.

Behaviour:
- Per-line storage: valid, dirty, tag and a 4x32 data block.
- States: IDLE, WRITEBACK, ALLOCATE.
- Reset (async, rst=1):
  - All valid and dirty bits cleared; tag and data contents don't-care.
  - State forced to IDLE.
  - Outputs: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_stall=0, proc_rdata=0.
  - Reset asserted mid-operation aborts any memory transaction with no further memory requests; memory must tolerate the abandoned request.
- IDLE:
  - hit = valid[idx] && tag[idx]==addr tag. req = proc_read|proc_write.
  - No req: proc_stall=0 and no state change.
  - Read hit: proc_stall=0 in the same cycle (combinational); proc_rdata = selected word.
  - Write hit: proc_stall=0; at the clock edge the selected word is written and dirty[idx] set. Bytes of the other words are untouched.
  - Miss on a clean or invalid line: proc_stall=1; next state ALLOCATE.
  - Miss on a valid dirty line: proc_stall=1; next state WRITEBACK.
  - proc_read and proc_write both high: treated as a write.
- WRITEBACK:
  - mem_write=1, mem_addr={stored tag, idx}, mem_wdata=stored block, proc_stall=1.
  - These outputs are held stable until the edge at which mem_ready=1, then next state is ALLOCATE.
- ALLOCATE:
  - mem_read=1, mem_addr={request tag, idx}, proc_stall=1; held until mem_ready=1.
  - On that edge: block := mem_rdata, tag := request tag, valid=1, dirty=0; next state IDLE.
  - The following IDLE cycle re-evaluates the request as a hit and completes it; a write sets dirty at that point.
- mem_read and mem_write are never high simultaneously. In IDLE both are 0.
- The core holds proc_* stable while proc_stall=1. Request changes during a miss are not supported; the block uses the live proc_addr.
- mem_ready arriving in IDLE is ignored.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: stall cycles = 1 + memory latency (cycles from mem_read asserted to mem_ready).
  - Dirty miss: adds the write-back latency.
- proc_rdata is 0 when no read is being served.

Test Plan:
- Reset, then proc_read addr 0x0000010 → proc_stall=1, mem_read=1, mem_addr=0x0000004. Memory returns 0x44443333_22221111_00000000_AAAAAAAA after 3 cycles → IDLE; next cycle proc_stall=0, proc_rdata=0xAAAAAAAA.
- Read hit at 0x0000011 right after the fill → proc_stall=0 in the same cycle, proc_rdata=0x00000000; mem_read stays 0.
- Write 0xDEADBEEF to 0x0000012 (hit) → no stall, dirty set. Then read 0x0000012 → 0xDEADBEEF.
- Read conflicting address 0x0000030 (same index, different tag) with the dirty line present → mem_write=1, mem_addr=0x0000004, mem_wdata word2=0xDEADBEEF. After mem_ready → mem_read=1, mem_addr=0x000000C, then completion.
- Assert rst during ALLOCATE while mem_read=1 → mem_read=0 and proc_stall=0 immediately. Re-reading 0x0000010 misses again because valid was cleared.
- proc_read and proc_write both low for 10 cycles with mem_ready pulsed randomly → no state change, mem_read=0, mem_write=0.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage
// and a 128-bit block memory bus; stalls the core until each request completes.
module dcache_responder #(
   parameter int NUM_LINES = 8,
   parameter int INDEX_W   = 3,
   parameter int TAG_W     = 25
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [127:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITEBACK,
      S_ALLOCATE
   } state_t;

   state_t               r_state;
   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [127:0]         r_data [NUM_LINES];

   logic [INDEX_W-1:0]   w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic [1:0]           w_off;
   logic [127:0]         w_line;
   logic [31:0]          w_word;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_wr_hit;
   logic                 w_fill;

   assign w_idx    = proc_addr[INDEX_W+1:2];
   assign w_tag    = proc_addr[29:INDEX_W+2];
   assign w_off    = proc_addr[1:0];
   assign w_line   = r_data[w_idx];
   assign w_req    = proc_read | proc_write;
   assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_wr_hit = (r_state == S_IDLE) && proc_write && w_hit;
   assign w_fill   = (r_state == S_ALLOCATE) && mem_ready;

   always_comb begin
      w_word = w_line[31:0];
      unique case (w_off)
         2'd0: w_word = w_line[31:0];
         2'd1: w_word = w_line[63:32];
         2'd2: w_word = w_line[95:64];
         2'd3: w_word = w_line[127:96];
      endcase
   end

   // Control state and line status bits are the only reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_hit) begin
                     if (proc_write) r_dirty[w_idx] <= 1'b1;
                  end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state <= S_WRITEBACK;
                  end else begin
                     r_state <= S_ALLOCATE;
                  end
               end
            end
            S_WRITEBACK: begin
               if (mem_ready) r_state <= S_ALLOCATE;
            end
            S_ALLOCATE: begin
               if (mem_ready) begin
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_hit) begin
         r_data[w_idx][{w_off, 5'd0} +: 32] <= proc_wdata;
      end else if (w_fill) begin
         r_data[w_idx] <= mem_rdata;
         r_tag[w_idx]  <= w_tag;
      end
   end

   // Hits must answer in the same cycle, so the core-side outputs are decoded.
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!rst) begin
         unique case (r_state)
            S_IDLE: begin
               proc_stall = w_req && !w_hit;
               if (proc_read && !proc_write && w_hit) proc_rdata = w_word;
            end
            S_WRITEBACK: begin
               proc_stall = 1'b1;
               mem_write  = 1'b1;
               mem_addr   = {r_tag[w_idx], w_idx};
               mem_wdata  = w_line;
            end
            S_ALLOCATE: begin
               proc_stall = 1'b1;
               mem_read   = 1'b1;
               mem_addr   = {w_tag, w_idx};
            end
            default: proc_stall = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed requests, a block memory
// model answering after a fixed latency, and queue-based response checking.
module tb_dcache_responder;

   localparam int LAT = 3;

   typedef struct {
      logic         wr;
      logic [27:0]  addr;
      logic [127:0] wd;
   } memop_t;

   logic         clk = 0;
   logic         rst;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         resp_ready, idle_ready;
   wire logic    mem_ready;

   assign mem_ready = resp_ready | idle_ready;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0]  rq[$];
   memop_t       mq[$];
   logic [127:0] mem_model [logic [27:0]];

   dcache_responder dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_req(input logic rd, input logic wr,
                         input logic [29:0] a, input logic [31:0] wd,
                         input logic [31:0] er, output int st);
      if (rd && !wr) rq.push_back(er);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = a;
      proc_wdata = wd;
      st = 0;
      forever begin
         @(negedge clk);
         if (!proc_stall) break;
         st++;
         if (st > 200) begin
            chk("req_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      proc_read  = 0;
      proc_write = 0;
   endtask

   // Core-side monitor: a read completes in a cycle with stall low.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && proc_read && !proc_write && !proc_stall) begin
            if (rq.size() == 0) chk("rdata_unexpected", 1, 0);
            else chk("rdata", proc_rdata, rq.pop_front());
         end
      end
   end

   // Memory model and bus monitor.
   initial begin
      logic         op_wr, held, aborted;
      logic [27:0]  op_addr;
      logic [127:0] op_wd;
      memop_t       e;
      resp_ready = 0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         resp_ready = 0;
         if (!rst && (mem_read || mem_write)) begin
            op_wr   = mem_write;
            op_addr = mem_addr;
            op_wd   = mem_wdata;
            held    = 1;
            aborted = 0;
            chk("mem_excl", mem_read & mem_write, 0);
            if (mq.size() == 0) begin
               chk("mem_unexpected", 1, 0);
            end else begin
               e = mq.pop_front();
               chk("mem_kind", op_wr, e.wr);
               chk("mem_addr", op_addr, e.addr);
               if (e.wr) chk("mem_wdata", op_wd, e.wd);
            end
            for (int i = 1; i < LAT; i++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1;
                  break;
               end
               if (mem_write != op_wr || mem_read != !op_wr ||
                   mem_addr != op_addr || (op_wr && mem_wdata != op_wd))
                  held = 0;
            end
            if (!aborted) begin
               chk("mem_hold", held, 1);
               if (op_wr) mem_model[op_addr] = op_wd;
               else mem_rdata = mem_model.exists(op_addr) ?
                                mem_model[op_addr] : '0;
               resp_ready = 1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int cnt;
      rst        = 1;
      proc_read  = 0;
      proc_write = 0;
      proc_addr  = '0;
      proc_wdata = '0;
      idle_ready = 0;
      mem_model[28'h4] = 128'h44443333_22221111_00000000_AAAAAAAA;
      mem_model[28'hC] = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_12345678;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", proc_stall, 0);
      chk("rst_rdata", proc_rdata, 0);
      chk("rst_mem_rd", mem_read, 0);
      chk("rst_mem_wr", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst = 0;

      // Cold miss on a clean line.
      mq.push_back('{wr: 0, addr: 28'h4, wd: '0});
      do_req(1, 0, 30'h10, 0, 32'hAAAAAAAA, st);
      chk("miss_stalls", st, 4);

      // Hit on the freshly filled block.
      do_req(1, 0, 30'h11, 0, 32'h0, st);
      chk("hit_stalls", st, 0);
      chk("hit_no_memrd", mem_read, 0);

      do_req(0, 1, 30'h12, 32'hDEADBEEF, 0, st);
      chk("whit_stalls", st, 0);
      do_req(1, 0, 30'h12, 0, 32'hDEADBEEF, st);
      chk("rhit_stalls", st, 0);
      do_req(1, 0, 30'h13, 0, 32'h44443333, st);

      // Conflict miss on the dirty line: write-back, then allocate.
      mq.push_back('{wr: 1, addr: 28'h4,
                     wd: 128'h44443333_DEADBEEF_00000000_AAAAAAAA});
      mq.push_back('{wr: 0, addr: 28'hC, wd: '0});
      do_req(1, 0, 30'h30, 0, 32'h12345678, st);
      chk("dirty_stalls", st, 7);

      // Reset in the middle of an allocate.
      mq.push_back('{wr: 0, addr: 28'h14, wd: '0});
      proc_read = 1;
      proc_addr = 30'h50;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!mem_read && cnt < 50);
      chk("alloc_seen", mem_read, 1);
      @(posedge clk);
      #2;
      rst = 1;
      #1;
      chk("abort_memrd", mem_read, 0);
      chk("abort_memwr", mem_write, 0);
      chk("abort_stall", proc_stall, 0);
      proc_read = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // Valid bits were cleared; the refill returns the written-back block.
      mq.push_back('{wr: 0, addr: 28'h4, wd: '0});
      do_req(1, 0, 30'h10, 0, 32'hAAAAAAAA, st);
      chk("remiss_stalls", st, 4);
      do_req(1, 0, 30'h12, 0, 32'hDEADBEEF, st);

      // Idle with stray mem_ready pulses.
      for (int i = 0; i < 10; i++) begin
         idle_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("idle_mem", {mem_read, mem_write, proc_stall}, 0);
         @(posedge clk);
         #1;
      end
      idle_ready = 0;
      do_req(1, 0, 30'h11, 0, 32'h0, st);
      chk("idle_hit_stalls", st, 0);

      repeat (10) @(negedge clk);
      chk("rq_empty", rq.size(), 0);
      chk("mq_empty", mq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
